// File: rtl/axis_fft8_pipe.sv
// axis_fft8_pipe: 8-point radix-2 DIF FFT/IFFT over AXI4-Stream, one frame per beat.
// Ports: s_axis_* frame in (+inv per beat), m_axis_* bins out, sat_count of clamped beats.
module axis_fft8_pipe #(
   parameter int IN_W    = 32,
   parameter int OUT_W   = 8,
   parameter int TUSER_W = 1,
   parameter int ROUND   = 0
) (
   input  logic                 s_axis_aclk,
   input  logic                 s_axis_areset,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   input  logic [16*IN_W-1:0]   s_axis_tdata,
   input  logic                 s_axis_tlast,
   input  logic [TUSER_W-1:0]   s_axis_tuser,
   input  logic                 s_axis_inv,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic [16*OUT_W-1:0]  m_axis_tdata,
   output logic                 m_axis_tlast,
   output logic [TUSER_W-1:0]   m_axis_tuser,
   output logic [15:0]          sat_count
);

   localparam int W  = IN_W + 3;
   localparam int PW = W + 18;

   typedef logic signed [W-1:0] cw_t;

   localparam logic signed [16:0] C = 17'sd23170;
   localparam logic signed [W:0] MAXV =
      {{(W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [W:0] MINV = ~MAXV;

   logic                en;
   logic [3:0]          vld_q, last_q, inv_q;
   logic [TUSER_W-1:0]  user_q [4];

   cw_t p0_re_d [8], p0_im_d [8], p0_re_q [8], p0_im_q [8];
   cw_t p1_re_d [8], p1_im_d [8], p1_re_q [8], p1_im_q [8];
   cw_t p2_re_d [8], p2_im_d [8], p2_re_q [8], p2_im_q [8];
   cw_t p3_re_d [8], p3_im_d [8], p3_re_q [8], p3_im_q [8];
   cw_t s_re [8], s_im [8];

   logic signed [W:0]   sc_re [8], sc_im [8];
   logic                sat_any;
   logic [16*OUT_W-1:0] out_data_d, out_data_q;
   logic                out_vld_q, out_last_q;
   logic [TUSER_W-1:0]  out_user_q;
   logic [15:0]         sat_q;

   // Stall the whole pipe only when a held output is not taken.
   assign en            = ~out_vld_q | m_axis_tready;
   assign s_axis_tready = en;

   assign m_axis_tvalid = out_vld_q;
   assign m_axis_tdata  = out_data_q;
   assign m_axis_tlast  = out_last_q;
   assign m_axis_tuser  = out_user_q;
   assign sat_count     = sat_q;

   // Q15 complex product real part: (a*c - b*d) >>> 15.
   // Imag part reuses it as (a*d - b*(-c)).
   function automatic cw_t twm(cw_t a, cw_t b,
                               logic signed [16:0] c,
                               logic signed [16:0] d);
      logic signed [PW-1:0] ax, bx, cx, dx, p;
      ax = {{(PW-W){a[W-1]}}, a};
      bx = {{(PW-W){b[W-1]}}, b};
      cx = {{(PW-17){c[16]}}, c};
      dx = {{(PW-17){d[16]}}, d};
      p  = ax * cx - bx * dx;
      return cw_t'(p >>> 15);
   endfunction

   function automatic logic signed [W:0] scale(cw_t v, logic inv);
      logic signed [W:0] x;
      x = {v[W-1], v};
      if (inv) begin
         if (ROUND != 0)
            x = x + {{(W-2){1'b0}}, 3'd4};
         x = x >>> 3;
      end
      return x;
   endfunction

   function automatic logic [OUT_W-1:0] clamp(logic signed [W:0] x);
      if (x > MAXV)
         return MAXV[OUT_W-1:0];
      else if (x < MINV)
         return MINV[OUT_W-1:0];
      return x[OUT_W-1:0];
   endfunction

   // P0: sign-extend, conjugate inverse beats on entry.
   always_comb begin
      for (int n = 0; n < 8; n++) begin
         p0_re_d[n] = {{3{s_axis_tdata[2*IN_W*n+2*IN_W-1]}},
                       s_axis_tdata[2*IN_W*n+IN_W +: IN_W]};
         p0_im_d[n] = {{3{s_axis_tdata[2*IN_W*n+IN_W-1]}},
                       s_axis_tdata[2*IN_W*n +: IN_W]};
         if (s_axis_inv)
            p0_im_d[n] = -p0_im_d[n];
      end
   end

   // P1: sums in [0..3], differences in [4..7].
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         p1_re_d[n]   = p0_re_q[n] + p0_re_q[n+4];
         p1_im_d[n]   = p0_im_q[n] + p0_im_q[n+4];
         p1_re_d[n+4] = p0_re_q[n] - p0_re_q[n+4];
         p1_im_d[n+4] = p0_im_q[n] - p0_im_q[n+4];
      end
   end

   // P2: twiddle the difference half by W8^n, then a 4-point
   // first stage on each half (-j folded into the last leg).
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         s_re[n] = p1_re_q[n];
         s_im[n] = p1_im_q[n];
      end
      s_re[4] = p1_re_q[4];
      s_im[4] = p1_im_q[4];
      s_re[5] = twm(p1_re_q[5], p1_im_q[5], C, -C);
      s_im[5] = twm(p1_re_q[5], p1_im_q[5], -C, -C);
      s_re[6] = p1_im_q[6];
      s_im[6] = -p1_re_q[6];
      s_re[7] = twm(p1_re_q[7], p1_im_q[7], -C, -C);
      s_im[7] = twm(p1_re_q[7], p1_im_q[7], -C, C);
      for (int g = 0; g < 2; g++) begin
         p2_re_d[4*g]   = s_re[4*g]   + s_re[4*g+2];
         p2_im_d[4*g]   = s_im[4*g]   + s_im[4*g+2];
         p2_re_d[4*g+1] = s_re[4*g+1] + s_re[4*g+3];
         p2_im_d[4*g+1] = s_im[4*g+1] + s_im[4*g+3];
         p2_re_d[4*g+2] = s_re[4*g]   - s_re[4*g+2];
         p2_im_d[4*g+2] = s_im[4*g]   - s_im[4*g+2];
         p2_re_d[4*g+3] = s_im[4*g+1] - s_im[4*g+3];
         p2_im_d[4*g+3] = s_re[4*g+3] - s_re[4*g+1];
      end
   end

   // P3: last butterflies, written straight into natural bin order.
   always_comb begin
      for (int g = 0; g < 2; g++) begin
         p3_re_d[g]   = p2_re_q[4*g]   + p2_re_q[4*g+1];
         p3_im_d[g]   = p2_im_q[4*g]   + p2_im_q[4*g+1];
         p3_re_d[g+4] = p2_re_q[4*g]   - p2_re_q[4*g+1];
         p3_im_d[g+4] = p2_im_q[4*g]   - p2_im_q[4*g+1];
         p3_re_d[g+2] = p2_re_q[4*g+2] + p2_re_q[4*g+3];
         p3_im_d[g+2] = p2_im_q[4*g+2] + p2_im_q[4*g+3];
         p3_re_d[g+6] = p2_re_q[4*g+2] - p2_re_q[4*g+3];
         p3_im_d[g+6] = p2_im_q[4*g+2] - p2_im_q[4*g+3];
      end
   end

   // P4: conjugate, scale, clamp.
   always_comb begin
      sat_any    = 1'b0;
      out_data_d = '0;
      for (int k = 0; k < 8; k++) begin
         sc_re[k] = scale(p3_re_q[k], inv_q[3]);
         sc_im[k] = scale(inv_q[3] ? -p3_im_q[k] : p3_im_q[k],
                          inv_q[3]);
         out_data_d[2*OUT_W*k +: 2*OUT_W] =
            {clamp(sc_re[k]), clamp(sc_im[k])};
         if (sc_re[k] > MAXV || sc_re[k] < MINV ||
             sc_im[k] > MAXV || sc_im[k] < MINV)
            sat_any = 1'b1;
      end
   end

   always_ff @(posedge s_axis_aclk) begin
      if (s_axis_areset) begin
         vld_q      <= '0;
         last_q     <= '0;
         inv_q      <= '0;
         for (int i = 0; i < 4; i++)
            user_q[i] <= '0;
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_last_q <= 1'b0;
         out_user_q <= '0;
         sat_q      <= '0;
      end else if (en) begin
         vld_q      <= {vld_q[2:0], s_axis_tvalid};
         last_q     <= {last_q[2:0], s_axis_tlast};
         inv_q      <= {inv_q[2:0], s_axis_inv};
         user_q[0]  <= s_axis_tuser;
         for (int i = 1; i < 4; i++)
            user_q[i] <= user_q[i-1];
         out_vld_q  <= vld_q[3];
         out_data_q <= out_data_d;
         out_last_q <= last_q[3];
         out_user_q <= user_q[3];
         if (vld_q[3] && sat_any && sat_q != 16'hFFFF)
            sat_q <= sat_q + 16'd1;
      end
   end

   always_ff @(posedge s_axis_aclk) begin
      if (en) begin
         p0_re_q <= p0_re_d;
         p0_im_q <= p0_im_d;
         p1_re_q <= p1_re_d;
         p1_im_q <= p1_im_d;
         p2_re_q <= p2_re_d;
         p2_im_q <= p2_im_d;
         p3_re_q <= p3_re_d;
         p3_im_q <= p3_im_d;
      end
   end

endmodule

// File: tb/tb_axis_fft8_pipe.sv
// tb_axis_fft8_pipe: directed bench for axis_fft8_pipe (ROUND=0 and ROUND=1 copies).
// Ports: drives one shared input stream into both instances, checks outputs.
module tb_axis_fft8_pipe;

   logic         clk = 1'b0;
   logic         rst;
   logic         s_tvalid, s_tlast, s_inv, m_tready;
   logic [511:0] s_tdata;
   logic [3:0]   s_tuser;

   logic         rdy0, rdy1, mv0, mv1, ml0, ml1;
   logic [127:0] md0, md1;
   logic [3:0]   mu0, mu1;
   logic [15:0]  sc0, sc1;

   int checks   = 0;
   int failures = 0;
   int xr [8];
   int xi [8];
   int er [8];
   int ei [8];

   always #5 clk = ~clk;

   axis_fft8_pipe #(.IN_W(32), .OUT_W(8), .TUSER_W(4), .ROUND(0)) dut0 (
      .s_axis_aclk(clk), .s_axis_areset(rst),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(rdy0),
      .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
      .s_axis_tuser(s_tuser), .s_axis_inv(s_inv),
      .m_axis_tvalid(mv0), .m_axis_tready(m_tready),
      .m_axis_tdata(md0), .m_axis_tlast(ml0),
      .m_axis_tuser(mu0), .sat_count(sc0)
   );

   axis_fft8_pipe #(.IN_W(32), .OUT_W(8), .TUSER_W(4), .ROUND(1)) dut1 (
      .s_axis_aclk(clk), .s_axis_areset(rst),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(rdy1),
      .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
      .s_axis_tuser(s_tuser), .s_axis_inv(s_inv),
      .m_axis_tvalid(mv1), .m_axis_tready(m_tready),
      .m_axis_tdata(md1), .m_axis_tlast(ml1),
      .m_axis_tuser(mu1), .sat_count(sc1)
   );

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] frame();
      logic [511:0] d;
      d = '0;
      for (int n = 0; n < 8; n++)
         d[n*64 +: 64] = {xr[n], xi[n]};
      return d;
   endfunction

   function automatic logic [127:0] pk();
      logic [127:0] r;
      r = '0;
      for (int k = 0; k < 8; k++)
         r[k*16 +: 16] = {er[k][7:0], ei[k][7:0]};
      return r;
   endfunction

   function automatic logic [127:0] rep(input int re, input int im);
      logic [127:0] r;
      r = '0;
      for (int k = 0; k < 8; k++)
         r[k*16 +: 16] = {re[7:0], im[7:0]};
      return r;
   endfunction

   function automatic logic [127:0] strm_exp(input int i);
      return (i % 2 == 0) ? rep(8*(i+1), 0) : rep(i+1, 0);
   endfunction

   task automatic clr_x();
      for (int n = 0; n < 8; n++) begin
         xr[n] = 0;
         xi[n] = 0;
      end
   endtask

   // Called #1 after a rising edge with an idle pipe.
   task automatic run_beat(input string tag, input logic inv,
                           input logic [127:0] e0,
                           input logic [127:0] e1);
      s_tdata  = frame();
      s_inv    = inv;
      s_tuser  = 4'hA;
      s_tlast  = 1'b1;
      s_tvalid = 1'b1;
      m_tready = 1'b1;
      #1;
      chk({tag, "_rdy"}, rdy0, 128'd1);
      @(posedge clk); #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = 4'h0;
      repeat (2) @(posedge clk);
      @(posedge clk); #1;
      chk({tag, "_lat3"}, mv0, 128'd0);
      @(posedge clk); #1;
      chk({tag, "_vld"}, mv0, 128'd1);
      chk({tag, "_d0"}, md0, e0);
      chk({tag, "_d1"}, md1, e1);
      chk({tag, "_sb"}, {mu0, ml0}, {4'hA, 1'b1});
      @(posedge clk); #1;
      chk({tag, "_end"}, mv0, 128'd0);
   endtask

   initial begin
      int tx, rx;
      logic acc, outx;
      rst = 1'b1;
      s_tvalid = 1'b0; s_tlast = 1'b0; s_inv = 1'b0;
      s_tuser = 4'h0; s_tdata = '0; m_tready = 1'b1;
      clr_x();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rst_vld", mv0, 128'd0);
      chk("rst_data", md0, 128'd0);
      chk("rst_sb", {mu0, ml0}, 128'd0);
      chk("rst_sat", sc0, 128'd0);
      chk("rst_rdy", rdy0, 128'd1);
      @(posedge clk); #1;

      clr_x(); xr[0] = 10;
      run_beat("fwd_imp", 1'b0, rep(10, 0), rep(10, 0));
      chk("fwd_imp_sat", sc0, 128'd0);

      clr_x(); xr[1] = 100;
      er = '{100, 70, 0, -71, -100, -70, 0, 71};
      ei = '{0, -71, -100, -70, 0, 71, 100, 70};
      run_beat("fwd_x1", 1'b0, pk(), pk());

      clr_x(); xr[3] = 100;
      er = '{100, -71, 0, 71, -100, 71, 0, -71};
      ei = '{0, -71, 100, -71, 0, 71, -100, 71};
      run_beat("fwd_x3", 1'b0, pk(), pk());

      clr_x(); xr[2] = 50;
      er = '{50, 0, -50, 0, 50, 0, -50, 0};
      ei = '{0, -50, 0, 50, 0, -50, 0, 50};
      run_beat("fwd_x2", 1'b0, pk(), pk());

      clr_x();
      for (int n = 0; n < 8; n++) xr[n] = 64;
      er = '{64, 0, 0, 0, 0, 0, 0, 0};
      ei = '{0, 0, 0, 0, 0, 0, 0, 0};
      run_beat("inv_dc", 1'b1, pk(), pk());

      clr_x(); xi[0] = 80;
      run_beat("inv_imag", 1'b1, rep(0, 10), rep(0, 10));

      clr_x(); xr[0] = 12;
      run_beat("rnd_pos", 1'b1, rep(1, 0), rep(2, 0));

      clr_x(); xr[0] = -12;
      run_beat("rnd_neg", 1'b1, rep(-2, 0), rep(-1, 0));
      chk("rnd_sat", sc0, 128'd0);

      clr_x(); xr[0] = 8192;
      run_beat("sat_pos", 1'b1, rep(127, 0), rep(127, 0));
      chk("sat_pos_cnt0", sc0, 128'd1);
      chk("sat_pos_cnt1", sc1, 128'd1);

      clr_x(); xr[0] = -8192;
      run_beat("sat_neg", 1'b1, rep(-128, 0), rep(-128, 0));
      chk("sat_neg_cnt0", sc0, 128'd2);
      chk("sat_neg_cnt1", sc1, 128'd2);

      tx = 0;
      rx = 0;
      for (int c = 0; c < 80 && rx < 6; c++) begin
         m_tready = !(c >= 5 && c < 10);
         s_tvalid = (tx < 6);
         clr_x();
         xr[0]    = 8 * (tx + 1);
         s_tdata  = frame();
         s_inv    = tx[0];
         s_tuser  = 4'(tx + 1);
         s_tlast  = (tx == 5);
         #1;
         if (mv0) begin
            chk("strm_data", md0, strm_exp(rx));
            chk("strm_sb", {mu0, ml0}, {4'(rx + 1), rx == 5});
         end
         acc  = s_tvalid && rdy0;
         outx = mv0 && m_tready;
         @(posedge clk); #1;
         if (acc) tx++;
         if (outx) rx++;
      end
      chk("strm_count", 128'(rx), 128'd6);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      m_tready = 1'b1;
      @(posedge clk); #1;
      chk("strm_idle", mv0, 128'd0);
      chk("strm_sat", sc0, 128'd2);

      clr_x(); xr[0] = 30;
      s_tdata  = frame();
      s_inv    = 1'b0;
      s_tuser  = 4'h3;
      s_tvalid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      rst      = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_sat", sc0, 128'd0);
      for (int i = 0; i < 6; i++) begin
         chk("mid_rst_quiet", mv0, 128'd0);
         @(posedge clk); #1;
      end
      clr_x(); xr[0] = 20;
      run_beat("post_rst", 1'b0, rep(20, 0), rep(20, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
